// File: rtl/l1_icache.sv
// l1_icache: direct-mapped read-only L1 instruction cache; define ICACHE_PERF_EN for hit/miss counters
module l1_icache #(
  parameter int NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic [15:0]  mem_address,
  output logic [127:0] mem_rdata,
  output logic         mem_resp,
  input  logic         flush,
  output logic         pmem_read,
  output logic [15:0]  pmem_address,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);
  localparam int IDX = $clog2(NUM_SETS);
  localparam int TW = 12 - IDX;
  typedef enum logic {IDLE, FETCH} state_t;
  state_t r_state, w_next;
  logic [NUM_SETS-1:0] r_valid;
  logic [TW-1:0] r_tag [NUM_SETS];
  logic [127:0] r_data [NUM_SETS];
  logic [15:0] r_paddr;
  logic r_flushed;
  logic [IDX-1:0] w_idx, w_fidx;
  logic [TW-1:0] w_tag, w_ftag;
  logic w_hit, w_miss, w_fill;
  assign w_idx = mem_address[3+IDX:4];
  assign w_tag = mem_address[15:4+IDX];
  assign w_fidx = r_paddr[3+IDX:4];
  assign w_ftag = r_paddr[15:4+IDX];
  assign mem_resp = w_hit;
  assign mem_rdata = r_data[w_idx];
  assign pmem_read = r_state == FETCH;
  assign pmem_address = r_paddr;
  // Next state: hits answer combinationally in IDLE, a fill always runs to pmem_resp
  always_comb begin
    w_next = r_state;
    w_hit = 1'b0;
    w_miss = 1'b0;
    w_fill = 1'b0;
    if (r_state == IDLE) begin
      w_hit = mem_read & r_valid[w_idx] & (r_tag[w_idx] == w_tag) & ~flush;
      w_miss = mem_read & ~w_hit & ~flush;
      w_next = w_miss ? FETCH : IDLE;
    end else begin
      w_fill = pmem_resp;
      w_next = pmem_resp ? IDLE : FETCH;
    end
  end
  // State, latched fill address, and whether a flush hit the fill in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_paddr <= '0;
      r_flushed <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_miss) begin
        r_paddr <= mem_address & 16'hFFF0;
        r_flushed <= 1'b0;
      end else if (flush) begin
        r_flushed <= 1'b1;
      end
    end
  end
  // Line storage: flush clears valids, a fill installs invalid if flushed during the fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < NUM_SETS; i++) begin
        r_tag[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (flush) r_valid <= '0;
      if (w_fill) begin
        r_tag[w_fidx] <= w_ftag;
        r_data[w_fidx] <= pmem_rdata;
        r_valid[w_fidx] <= ~(flush | r_flushed);
      end
    end
  end
`ifdef ICACHE_PERF_EN
  logic [15:0] r_hits, r_misses;
  // Saturating performance counters, untouched by flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hits <= '0;
      r_misses <= '0;
    end else begin
      if (w_hit && r_hits != 16'hFFFF) r_hits <= r_hits + 16'd1;
      if (w_miss && r_misses != 16'hFFFF) r_misses <= r_misses + 16'd1;
    end
  end
  assign hit_count = r_hits;
  assign miss_count = r_misses;
`else
  assign hit_count = 16'h0000;
  assign miss_count = 16'h0000;
`endif
endmodule
